// File: rtl/dt_pkg.sv
// ----------------------------------------------------------------------------
// dt_pkg
// Shared definitions for the distance-transform engine and its companion
// blocks. Holds the image geometry, the packer state encoding and a helper
// that maps a row-major pixel index to its packed-word location.
//
// Contents:
//   IMG_W, IMG_H     image geometry in pixels
//   PIX_N, WORD_N    pixel count and packed-word count of one frame
//   WORD_W           pixels per packed word
//   PIX_AW, WORD_AW  pixel and packed-word address widths
//   ST_*             packer FSM state constants
//   pix_to_loc()     pixel index -> {word index, bit position}
// ----------------------------------------------------------------------------
package dt_pkg;

  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int PIX_N   = IMG_W * IMG_H;
  localparam int WORD_W  = 16;
  localparam int WORD_N  = PIX_N / WORD_W;
  localparam int PIX_AW  = 14;
  localparam int WORD_AW = 10;

  // Packer FSM encoding. Kept as plain vectors so older tools and the
  // distance engine's existing state decode can share it unchanged.
  typedef logic [1:0] pk_state_t;

  localparam pk_state_t ST_IDLE  = 2'd0;
  localparam pk_state_t ST_RUN   = 2'd1;
  localparam pk_state_t ST_DRAIN = 2'd2;
  localparam pk_state_t ST_DONE  = 2'd3;

  // Location of one pixel inside the packed image.
  typedef struct packed {
    logic [WORD_AW-1:0] word;
    logic [3:0]         bit_pos;
  } pix_loc_t;

  // Pixels are packed MSB-first: the lowest pixel index of a word lands in
  // bit 15, so the bit position counts down as the pixel index counts up.
  function automatic pix_loc_t pix_to_loc(input logic [PIX_AW-1:0] pix);
    pix_loc_t loc;
    loc.word    = pix[PIX_AW-1:4];
    loc.bit_pos = 4'd15 - pix[3:0];
    return loc;
  endfunction

endpackage

// File: rtl/dt_word_packer.sv
// ----------------------------------------------------------------------------
// dt_word_packer
// Collects a stream of single-bit pixels into 16-bit words, MSB first, and
// emits each completed word with its word address as a one-cycle write.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear      in   restart packing from word 0 (frame start)
//   bit_valid  in   bit_in carries a pixel this cycle
//   bit_in     in   thresholded pixel value
//   pk_wr      out  one-cycle write strobe for a completed word
//   pk_addr    out  address of the word on pk_do
//   pk_do      out  completed word, bit 15 = earliest pixel
// ----------------------------------------------------------------------------
module dt_word_packer
  import dt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               pk_wr,
  output logic [WORD_AW-1:0] pk_addr,
  output logic [WORD_W-1:0]  pk_do
);

  // Only the first 15 pixels of a word need storing: the 16th is merged
  // straight into pk_do on the cycle it arrives.
  logic [WORD_W-2:0]  shift;
  logic [3:0]         cap_cnt;
  logic [WORD_AW-1:0] word_cnt;

  // Shift in one pixel per valid cycle. When the capture counter is about
  // to wrap, the word is complete and is written out together with the
  // current word count, which then advances. A clear drops any partly
  // collected word so a new frame always starts on a word boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift    <= '0;
      cap_cnt  <= '0;
      word_cnt <= '0;
      pk_wr    <= 1'b0;
      pk_addr  <= '0;
      pk_do    <= '0;
    end else begin
      pk_wr <= 1'b0;
      if (clear) begin
        shift    <= '0;
        cap_cnt  <= '0;
        word_cnt <= '0;
      end else if (bit_valid) begin
        shift   <= {shift[WORD_W-3:0], bit_in};
        cap_cnt <= cap_cnt + 4'd1;
        if (cap_cnt == 4'd15) begin
          pk_do    <= {shift, bit_in};
          pk_addr  <= word_cnt;
          pk_wr    <= 1'b1;
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dt_res_packer.sv
// ----------------------------------------------------------------------------
// dt_res_packer
// Reads the 128x128 8-bit result map from the res RAM, thresholds every
// pixel to one bit and writes the 1024 packed 16-bit words to the packed
// image RAM in the same layout as the sti ROM.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   begin a frame (accepted in IDLE or DONE)
//   thr       in   threshold, captured when start is accepted
//   res_rd    out  res RAM read enable
//   res_addr  out  res RAM pixel address, row-major
//   res_di    in   res RAM read data, one cycle after the address
//   pk_wr     out  packed RAM write strobe, one pulse per word
//   pk_addr   out  packed word address
//   pk_do     out  packed word, bit 15 = lowest pixel index
//   busy      out  frame in progress
//   done      out  frame complete, held until the next start
// ----------------------------------------------------------------------------
module dt_res_packer
  import dt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         thr,
  output logic               res_rd,
  output logic [PIX_AW-1:0]  res_addr,
  input  logic [7:0]         res_di,
  output logic               pk_wr,
  output logic [WORD_AW-1:0] pk_addr,
  output logic [WORD_W-1:0]  pk_do,
  output logic               busy,
  output logic               done
);

  pk_state_t  state;
  logic [7:0] thr_q;
  logic       rd_vld;
  logic       accept;
  logic       pix_bit;
  logic       last_word;

  // A new frame may only begin from an idle or finished state; requests
  // arriving while a frame runs are simply ignored.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // The RAM returns data one cycle after the read, so rd_vld (res_rd
  // delayed by one clock) marks the cycles where res_di holds a pixel.
  assign pix_bit = (res_di >= thr_q);

  // The final word of the frame is on the packed bus this cycle.
  assign last_word = pk_wr && (pk_addr == WORD_AW'(WORD_N - 1));

  // Frame sequencing and read address generation. RUN issues one address
  // per cycle; once the last pixel address is out, DRAIN lets the read
  // pipeline and the packer flush until the last word has been written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      thr_q    <= '0;
      rd_vld   <= 1'b0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_vld <= res_rd;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            thr_q    <= thr;
            res_rd   <= 1'b1;
            res_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (res_addr == PIX_AW'(PIX_N - 1)) begin
            res_rd <= 1'b0;
            state  <= ST_DRAIN;
          end else begin
            res_addr <= res_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_word) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bit packing and word emission live in the sub-module; it is restarted
  // on every accepted start so word addresses always begin at 0.
  dt_word_packer u_word_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_valid (rd_vld),
    .bit_in    (pix_bit),
    .pk_wr     (pk_wr),
    .pk_addr   (pk_addr),
    .pk_do     (pk_do)
  );

endmodule

// File: tb/tb_dt_res_packer.sv
// ----------------------------------------------------------------------------
// tb_dt_res_packer
// Self-checking bench for dt_res_packer. A behavioural res RAM feeds the
// design; every written word is collected and compared against words built
// directly from the pixel array and threshold.
// ----------------------------------------------------------------------------
module tb_dt_res_packer;

  localparam int PIX   = 16384;
  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        pk_wr;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic        busy;
  logic        done;

  logic [7:0]  mem [PIX];
  logic [15:0] got [WORDS];
  logic [15:0] sti [WORDS];

  int          checks = 0;
  int          failures = 0;
  int          got_count;
  int          bad_addr;
  int          bad_timing;
  logic [7:0]  frame_thr;

  always #5 clk = ~clk;

  dt_res_packer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .pk_wr    (pk_wr),
    .pk_addr  (pk_addr),
    .pk_do    (pk_do),
    .busy     (busy),
    .done     (done)
  );

  // Synchronous-read res RAM: data appears the cycle after the address.
  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  // Reference word: pixel 16w+i goes to bit 15-i, set when pixel >= thr.
  function automatic logic [15:0] modelWord(input int w, input logic [7:0] t);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15 - i] = (mem[16 * w + i] >= t);
    return r;
  endfunction

  // Launch a frame: start is sampled at edge E0; returns at the negedge
  // after E0. With hold set, start stays high afterwards.
  task automatic applyStimulus(input logic [7:0] t, input bit hold);
    frame_thr  = t;
    got_count  = 0;
    bad_addr   = 0;
    bad_timing = 0;
    for (int i = 0; i < WORDS; i++) got[i] = 'x;
    @(negedge clk);
    thr   = t;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_rd", res_rd, 1);
    checkOutput("start_addr", res_addr, 0);
    checkOutput("start_done", done, 0);
  endtask

  // Watch edges 1..last_edge after E0, sampling at each negedge. A start
  // pulse with thr=0 is injected after mid_edge when mid_edge > 0.
  task automatic runEdges(input int last_edge, input int mid_edge);
    for (int e = 1; e <= last_edge; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (mid_edge > 0 && e == mid_edge) begin
        start = 1'b1;
        thr   = 8'd0;
      end else if (mid_edge > 0 && e == mid_edge + 1) begin
        start = 1'b0;
      end
      if (pk_wr) begin
        if (got_count >= WORDS || pk_addr !== 10'(got_count)) bad_addr++;
        if (e != 16 * got_count + 17) bad_timing++;
        got[pk_addr] = pk_do;
        got_count++;
      end
      if (e == 16383) begin
        checkOutput("last_addr_rd", res_rd, 1);
        checkOutput("last_addr", res_addr, 16383);
      end
      if (e == 16384) begin
        checkOutput("rd_off", res_rd, 0);
        checkOutput("addr_hold", res_addr, 16383);
      end
      if (e == 16385) begin
        checkOutput("pre_done", done, 0);
        checkOutput("pre_done_busy", busy, 1);
      end
      if (e == 16386) begin
        checkOutput("done_set", done, 1);
        checkOutput("busy_clr", busy, 0);
        checkOutput("final_addr", pk_addr, 1023);
      end
    end
  endtask

  task automatic checkFrame(input int n_words, input string tag);
    int bad;
    bad = 0;
    checkOutput({tag, "_count"}, got_count, n_words);
    checkOutput({tag, "_addr_order"}, bad_addr, 0);
    checkOutput({tag, "_timing"}, bad_timing, 0);
    for (int w = 0; w < n_words; w++)
      if (got[w] !== modelWord(w, frame_thr)) bad++;
    checkOutput({tag, "_data_errs"}, bad, 0);
  endtask

  initial begin
    int idle_bad;
    int rt_bad;

    reset = 1'b0;
    start = 1'b0;
    thr   = 8'd0;
    for (int p = 0; p < PIX; p++) mem[p] = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_rd", res_rd, 0);
    checkOutput("rst_addr", res_addr, 0);
    checkOutput("rst_wr", pk_wr, 0);
    checkOutput("rst_pk_addr", pk_addr, 0);
    checkOutput("rst_pk_do", pk_do, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // Frame 1: sparse pixels at word boundaries, thr=1
    mem[15]    = 8'd1;
    mem[16]    = 8'd2;
    mem[16383] = 8'd3;
    applyStimulus(8'd1, 1'b0);
    runEdges(16386, -1);
    checkFrame(WORDS, "f1");
    checkOutput("f1_w0", got[0], 16'h0001);
    checkOutput("f1_w1", got[1], 16'h8000);
    checkOutput("f1_w2", got[2], 16'h0000);
    checkOutput("f1_w1023", got[1023], 16'h0001);
    repeat (3) @(negedge clk);
    checkOutput("done_held", done, 1);
    checkOutput("pk_addr_held", pk_addr, 1023);
    checkOutput("pk_do_held", pk_do, 16'h0001);

    // Frame 2: ramp in word 0, random small values, mid-frame start/thr change
    for (int p = 0; p < PIX; p++) mem[p] = 8'($urandom_range(0, 7));
    for (int p = 0; p < 16; p++) mem[p] = 8'(p);
    applyStimulus(8'd3, 1'b0);
    runEdges(16386, 8000);
    checkFrame(WORDS, "f2");
    checkOutput("f2_w0", got[0], 16'h1FFF);

    // Reset in the middle of a frame
    for (int p = 0; p < PIX; p++) mem[p] = 8'($urandom);
    applyStimulus(8'd7, 1'b0);
    runEdges(5000, -1);
    checkOutput("pre_rst_busy", busy, 1);
    checkOutput("pre_rst_pk_addr", pk_addr, 311);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_rd", res_rd, 0);
    checkOutput("mid_rst_addr", res_addr, 0);
    checkOutput("mid_rst_wr", pk_wr, 0);
    checkOutput("mid_rst_pk_addr", pk_addr, 0);
    checkOutput("mid_rst_pk_do", pk_do, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pk_wr !== 1'b0 || busy !== 1'b0 || res_rd !== 1'b0) idle_bad++;
    end
    checkOutput("post_rst_quiet", idle_bad, 0);

    // Frame 3: thr=0 after reset -> every word all ones
    for (int p = 0; p < PIX; p++) mem[p] = 8'($urandom);
    applyStimulus(8'd0, 1'b0);
    runEdges(16386, -1);
    checkFrame(WORDS, "f3");
    checkOutput("f3_w500", got[500], 16'hFFFF);

    // Frame 4: round trip of an init-phase image, start held high
    for (int w = 0; w < WORDS; w++) sti[w] = 16'($urandom);
    for (int p = 0; p < PIX; p++) begin
      logic [15:0] sw;
      sw     = sti[p / 16];
      mem[p] = {7'd0, sw[15 - (p % 16)]};
    end
    applyStimulus(8'd1, 1'b1);
    runEdges(16386, -1);
    checkOutput("rt_count", got_count, WORDS);
    rt_bad = 0;
    for (int w = 0; w < WORDS; w++) if (got[w] !== sti[w]) rt_bad++;
    checkOutput("rt_data_errs", rt_bad, 0);
    checkOutput("rt_w0", got[0], sti[0]);

    // Frame 5: held start restarts on the first edge in DONE, thr=255
    thr = 8'd255;
    for (int p = 0; p < PIX; p++)
      mem[p] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(250, 254));
    frame_thr  = 8'd255;
    got_count  = 0;
    bad_addr   = 0;
    bad_timing = 0;
    for (int i = 0; i < WORDS; i++) got[i] = 'x;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_done", done, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_addr", res_addr, 0);
    runEdges(2000, -1);
    checkFrame(124, "f5");

    reset = 1'b0;
    #1;
    checkOutput("end_rst_busy", busy, 0);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
